// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: one command in, one NONSEQ transfer on the bus, one response out.
// Illegal sizes or misaligned addresses are answered with an error and never reach the bus.
module ahb_lite_master #(
   parameter int unsigned AWIDTH = 32,
   parameter int unsigned WCNT_W = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [31:0]       CMD_WDATA,
   input  logic [2:0]        CMD_SIZE,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERROR,
   output logic [WCNT_W-1:0] RSP_WAITS,
   output logic [AWIDTH-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [1:0]        HTRANS,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_write;
   logic [AWIDTH-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [2:0]          r_size;

   logic [WCNT_W-1:0]   r_wcnt;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_error;
   logic [WCNT_W-1:0]   r_rsp_waits;

   logic                w_accept;
   logic                w_illegal;
   logic                w_stall;

   assign w_accept  = CMD_VALID && (r_state == S_IDLE);
   assign w_illegal = (CMD_SIZE > 3'd2)
                   || ((CMD_SIZE == 3'd1) && CMD_ADDR[0])
                   || ((CMD_SIZE == 3'd2) && (CMD_ADDR[1:0] != 2'b00));
   // A wait cycle is any cycle of a live bus transfer with HREADY low.
   assign w_stall   = ((r_state == S_ADDR) || (r_state == S_DATA)) && !HREADY;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_illegal ? S_RESP : S_ADDR;
         S_ADDR: if (HREADY)   w_state_nxt = S_DATA;
         S_DATA: if (HREADY)   w_state_nxt = S_RESP;
         S_RESP:               w_state_nxt = S_IDLE;
         default:              w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      CMD_READY = 1'b0;
      RSP_VALID = 1'b0;
      HTRANS    = HTRANS_IDLE;
      HADDR     = '0;
      HWRITE    = 1'b0;
      HSIZE     = 3'd0;
      HBURST    = 3'd0;
      HMASTLOCK = 1'b0;
      HPROT     = 4'd0;
      HWDATA    = 32'd0;
      case (r_state)
         S_IDLE: CMD_READY = 1'b1;
         S_ADDR: begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = r_addr;
            HWRITE = r_write;
            HSIZE  = r_size;
            HPROT  = HPROT_DATA;
         end
         S_DATA: HWDATA = r_write ? r_wdata : 32'd0;
         S_RESP: RSP_VALID = 1'b1;
         default: ;
      endcase
   end

   // Command holding registers, loaded on acceptance only.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_size  <= 3'd0;
      end else if (w_accept) begin
         r_write <= CMD_WRITE;
         r_addr  <= CMD_ADDR;
         r_wdata <= CMD_WDATA;
         r_size  <= CMD_SIZE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_wcnt <= '0;
      end else if (w_accept) begin
         r_wcnt <= '0;
      end else if (w_stall && !(&r_wcnt)) begin
         r_wcnt <= r_wcnt + WCNT_W'(1);
      end
   end

   // Response fields change only when a new response is produced.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_rsp_rdata <= 32'd0;
         r_rsp_error <= 1'b0;
         r_rsp_waits <= '0;
      end else if (w_accept && w_illegal) begin
         r_rsp_rdata <= 32'd0;
         r_rsp_error <= 1'b1;
         r_rsp_waits <= '0;
      end else if ((r_state == S_DATA) && HREADY) begin
         r_rsp_rdata <= r_write ? 32'd0 : HRDATA;
         r_rsp_error <= HRESP;
         r_rsp_waits <= r_wcnt;
      end
   end

   assign RSP_RDATA = r_rsp_rdata;
   assign RSP_ERROR = r_rsp_error;
   assign RSP_WAITS = r_rsp_waits;

endmodule
